pipeline_ctrl: RTL

//  Sequences the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage core.

---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared core types: register index type and pipeline controller states.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory status from the datapath and latch/PC/memory controls back to it.
interface pipeline_ctrl_if #(parameter int unsigned CNT_W = 32);

  logic                      ihit;
  logic                      dhit;
  logic                      mem_DRen;
  logic                      mem_DWen;
  logic                      mem_redirect;
  logic                      wb_halt;
  logic                      idex_DRen;
  cpu_types_pkg::regbits_t   idex_rdst;
  cpu_types_pkg::regbits_t   ifid_rs;
  cpu_types_pkg::regbits_t   ifid_rt;

  logic                      pc_en;
  logic                      pc_sel;
  logic                      ifid_en;
  logic                      idex_en;
  logic                      exmem_en;
  logic                      memwb_en;
  logic                      ifid_flush;
  logic                      idex_flush;
  logic                      exmem_flush;
  logic                      memwb_flush;
  logic                      imemREN;
  logic                      dmemREN;
  logic                      dmemWEN;
  logic                      halt;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output ihit, dhit, mem_DRen, mem_DWen, mem_redirect, wb_halt,
           idex_DRen, idex_rdst, ifid_rs, ifid_rt,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           imemREN, dmemREN, dmemWEN, halt, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_DRen, mem_DWen, mem_redirect, wb_halt,
           idex_DRen, idex_rdst, ifid_rs, ifid_rt,
    output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           imemREN, dmemREN, dmemWEN, halt, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: load in EX writing a register that ID is about to read.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_DRen,
  input  regbits_t idex_rdst,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);

  always_comb begin
    load_use = idex_DRen && (idex_rdst != '0) &&
               ((idex_rdst == ifid_rs) || (idex_rdst == ifid_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per cycle chooses advance, freeze, load-use bubble or redirect flush.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  pipeline_ctrl_if.slave bus
);

  pctrl_state_t     state_q, state_d;
  logic             ifetch_done_q, ifetch_done_d;
  logic             dmem_done_q, dmem_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic i_ok, d_ok, adv, bubble;

  hazard_detect u_hazard_detect (
    .idex_DRen (bus.idex_DRen),
    .idex_rdst (bus.idex_rdst),
    .ifid_rs   (bus.ifid_rs),
    .ifid_rt   (bus.ifid_rt),
    .load_use  (load_use)
  );

  always_comb begin
    state_d         = state_q;
    ifetch_done_d   = ifetch_done_q;
    dmem_done_d     = dmem_done_q;
    stall_cnt_d     = stall_cnt_q;
    i_ok            = 1'b0;
    d_ok            = 1'b0;
    adv             = 1'b0;
    bubble          = 1'b0;
    bus.pc_en       = 1'b0;
    bus.pc_sel      = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.idex_en     = 1'b0;
    bus.exmem_en    = 1'b0;
    bus.memwb_en    = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;
    bus.memwb_flush = 1'b0;
    bus.imemREN     = 1'b0;
    bus.dmemREN     = 1'b0;
    bus.dmemWEN     = 1'b0;
    bus.halt        = 1'b0;

    unique case (state_q)
      IDLE: state_d = RUN;

      RUN: begin
        bus.imemREN = !ifetch_done_q;
        bus.dmemREN = bus.mem_DRen && !dmem_done_q;
        bus.dmemWEN = bus.mem_DWen && !dmem_done_q;
        i_ok = bus.ihit || ifetch_done_q;
        d_ok = !(bus.mem_DRen || bus.mem_DWen) || bus.dhit || dmem_done_q;
        // A halting cycle freezes like a miss, but requests above stay driven.
        adv  = i_ok && d_ok && !bus.wb_halt;

        if (bus.wb_halt) begin
          state_d       = HALTED;
          ifetch_done_d = 1'b0;
          dmem_done_d   = 1'b0;
        end else if (adv) begin
          ifetch_done_d = 1'b0;
          dmem_done_d   = 1'b0;
        end else begin
          ifetch_done_d = ifetch_done_q || bus.ihit;
          dmem_done_d   = dmem_done_q || bus.dhit;
        end

        if (adv && bus.mem_redirect) begin
          bus.pc_en       = 1'b1;
          bus.pc_sel      = 1'b1;
          bus.ifid_flush  = 1'b1;
          bus.idex_flush  = 1'b1;
          bus.exmem_flush = 1'b1;
          bus.memwb_en    = 1'b1;
        end else if (adv && load_use) begin
          bubble          = 1'b1;
          bus.idex_flush  = 1'b1;
          bus.exmem_en    = 1'b1;
          bus.memwb_en    = 1'b1;
        end else if (adv) begin
          bus.pc_en       = 1'b1;
          bus.ifid_en     = 1'b1;
          bus.idex_en     = 1'b1;
          bus.exmem_en    = 1'b1;
          bus.memwb_en    = 1'b1;
        end

        if ((!adv || bubble) && (stall_cnt_q != '1)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end

      HALTED: bus.halt = 1'b1;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      ifetch_done_q <= 1'b0;
      dmem_done_q   <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ifetch_done_q <= ifetch_done_d;
      dmem_done_q   <= dmem_done_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule
